unidade_controle_jogo: RTL and testbench

//  Moore FSM that sequences the experiment-4 datapath (counter, play register, sync ROM,

---
 rtl/unidade_controle_jogo_pkg.sv | 20 ++
 rtl/unidade_controle_jogo_contador_timeout.sv | 23 ++
 rtl/unidade_controle_jogo.sv | 97 +++++++++
 tb/tb_unidade_controle_jogo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_jogo_pkg.sv
// Shared state encoding for the experiment-4 game controller; the bench decodes db_estado against the same codes.
package unidade_controle_jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  function automatic logic is_fim(estado_t e);
    return (e == FIM_ACERTOU) || (e == FIM_ERROU) || (e == FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Free-running wait counter for ESPERA; fim flags the last allowed cycle.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [TW-1:0] cnt,
  output logic          fim
);

  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + 1'b1;
  end

  assign fim = (cnt == TW'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore controller that sequences the play/compare/advance loop of the ROM-matching game.
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t       estado;
  estado_t       proximo_estado;
  logic [TW-1:0] cnt_espera;
  logic          fim_espera;
  logic          limpa_espera;

  // Counter restarts on every entry to ESPERA and reads 0 everywhere outside it.
  assign limpa_espera = (estado != ESPERA) || (proximo_estado != ESPERA);

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .TW            (TW)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .clear (limpa_espera),
    .enable(estado == ESPERA),
    .cnt   (cnt_espera),
    .fim   (fim_espera)
  );

  always_comb begin
    proximo_estado = INICIAL;
    case (estado)
      INICIAL:     proximo_estado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  proximo_estado = ESPERA;
      ESPERA: begin
        if (jogada_feita)    proximo_estado = REGISTRA;
        else if (fim_espera) proximo_estado = FIM_TIMEOUT;
        else                 proximo_estado = ESPERA;
      end
      REGISTRA:    proximo_estado = COMPARACAO;
      COMPARACAO: begin
        if (!igual)    proximo_estado = FIM_ERROU;
        else if (fimC) proximo_estado = FIM_ACERTOU;
        else           proximo_estado = PROXIMO;
      end
      PROXIMO:     proximo_estado = ESPERA;
      FIM_ACERTOU,
      FIM_TIMEOUT,
      FIM_ERROU:   proximo_estado = iniciar ? PREPARACAO : estado;
      default:     proximo_estado = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so they land together with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= INICIAL;
      zeraC     <= 1'b0;
      contaC    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      estado    <= proximo_estado;
      zeraC     <= (proximo_estado == PREPARACAO);
      zeraR     <= (proximo_estado == PREPARACAO);
      contaC    <= (proximo_estado == PROXIMO);
      registraR <= (proximo_estado == REGISTRA);
      pronto    <= is_fim(proximo_estado);
      acertou   <= (proximo_estado == FIM_ACERTOU);
      errou     <= (proximo_estado == FIM_ERROU);
      timeout   <= (proximo_estado == FIM_TIMEOUT);
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo with an 8-cycle timeout; datapath inputs are driven by hand.
module tb_unidade_controle_jogo;
  import unidade_controle_jogo_pkg::*;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada_feita, igual, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  wire [11:0] obs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado};

  // Flag order: zeraC contaC zeraR registraR pronto acertou errou timeout
  localparam logic [7:0] F_NONE  = 8'b0000_0000;
  localparam logic [7:0] F_PREP  = 8'b1010_0000;
  localparam logic [7:0] F_CONTA = 8'b0100_0000;
  localparam logic [7:0] F_REG   = 8'b0001_0000;
  localparam logic [7:0] F_ACERT = 8'b0000_1100;
  localparam logic [7:0] F_ERR   = 8'b0000_1010;
  localparam logic [7:0] F_TO    = 8'b0000_1001;

  int tests_run = 0;
  int tests_failed = 0;
  int conta_pulsos = 0;
  int registra_pulsos = 0;

  always #5 clock = ~clock;

  unidade_controle_jogo #(
    .TIMEOUT_CICLOS(8),
    .TW            (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .jogada_feita(jogada_feita),
    .igual       (igual),
    .fimC        (fimC),
    .zeraC       (zeraC),
    .contaC      (contaC),
    .zeraR       (zeraR),
    .registraR   (registraR),
    .pronto      (pronto),
    .acertou     (acertou),
    .errou       (errou),
    .timeout     (timeout),
    .db_estado   (db_estado)
  );

  task automatic tick();
    @(negedge clock);
    if (contaC) conta_pulsos++;
    if (registraR) registra_pulsos++;
  endtask

  task automatic play(input logic ig, input logic fc);
    jogada_feita = 1'b1; igual = ig; fimC = fc;
    tick();
    tests_run++;
    if (obs !== {F_REG, 4'h4}) begin tests_failed++; $display("[TB] FAIL play_registra got=%h exp=%h", obs, {F_REG, 4'h4}); end
    jogada_feita = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h5}) begin tests_failed++; $display("[TB] FAIL play_comparacao got=%h exp=%h", obs, {F_NONE, 4'h5}); end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b1; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;
    tick(); tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h0}) begin tests_failed++; $display("[TB] FAIL reset_hold got=%h exp=%h", obs, {F_NONE, 4'h0}); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_PREP, 4'h1}) begin tests_failed++; $display("[TB] FAIL reset_release_prep got=%h exp=%h", obs, {F_PREP, 4'h1}); end
    iniciar = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h2}) begin tests_failed++; $display("[TB] FAIL prep_to_espera got=%h exp=%h", obs, {F_NONE, 4'h2}); end
  endtask

  task automatic test_success();
    conta_pulsos = 0;
    for (int i = 0; i < 16; i++) begin
      play(1'b1, (i == 15));
      if (i < 15) begin
        tests_run++;
        if (obs !== {F_CONTA, 4'h6}) begin tests_failed++; $display("[TB] FAIL success_proximo[%0d] got=%h exp=%h", i, obs, {F_CONTA, 4'h6}); end
        tick();
        tests_run++;
        if (obs !== {F_NONE, 4'h2}) begin tests_failed++; $display("[TB] FAIL success_espera[%0d] got=%h exp=%h", i, obs, {F_NONE, 4'h2}); end
      end
    end
    tests_run++;
    if (obs !== {F_ACERT, 4'hA}) begin tests_failed++; $display("[TB] FAIL success_fim got=%h exp=%h", obs, {F_ACERT, 4'hA}); end
    tests_run++;
    if (conta_pulsos != 15) begin tests_failed++; $display("[TB] FAIL success_contaC got=%0d exp=15", conta_pulsos); end
  endtask

  task automatic test_error();
    iniciar = 1'b1;
    tick();
    tests_run++;
    if (obs !== {F_PREP, 4'h1}) begin tests_failed++; $display("[TB] FAIL error_prep got=%h exp=%h", obs, {F_PREP, 4'h1}); end
    iniciar = 1'b0;
    tick();
    conta_pulsos = 0;
    for (int i = 0; i < 2; i++) begin
      play(1'b1, 1'b0);
      tests_run++;
      if (obs !== {F_CONTA, 4'h6}) begin tests_failed++; $display("[TB] FAIL error_proximo[%0d] got=%h exp=%h", i, obs, {F_CONTA, 4'h6}); end
      tick();
    end
    play(1'b0, 1'b0);
    tests_run++;
    if (obs !== {F_ERR, 4'hE}) begin tests_failed++; $display("[TB] FAIL error_fim got=%h exp=%h", obs, {F_ERR, 4'hE}); end
    tests_run++;
    if (conta_pulsos != 2) begin tests_failed++; $display("[TB] FAIL error_contaC got=%0d exp=2", conta_pulsos); end
  endtask

  task automatic test_restart();
    tick();
    tests_run++;
    if (obs !== {F_ERR, 4'hE}) begin tests_failed++; $display("[TB] FAIL restart_flag_hold got=%h exp=%h", obs, {F_ERR, 4'hE}); end
    iniciar = 1'b1;
    tick();
    tests_run++;
    if (obs !== {F_PREP, 4'h1}) begin tests_failed++; $display("[TB] FAIL restart_prep got=%h exp=%h", obs, {F_PREP, 4'h1}); end
    iniciar = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h2}) begin tests_failed++; $display("[TB] FAIL restart_espera got=%h exp=%h", obs, {F_NONE, 4'h2}); end
    registra_pulsos = 0;
    jogada_feita = 1'b1; igual = 1'b1; fimC = 1'b0;
    tick();
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h5}) begin tests_failed++; $display("[TB] FAIL restart_ignore_comparacao got=%h exp=%h", obs, {F_NONE, 4'h5}); end
    tick();
    tests_run++;
    if (obs !== {F_CONTA, 4'h6}) begin tests_failed++; $display("[TB] FAIL restart_ignore_proximo got=%h exp=%h", obs, {F_CONTA, 4'h6}); end
    jogada_feita = 1'b0;
    tick();
    tests_run++;
    if (registra_pulsos != 1) begin tests_failed++; $display("[TB] FAIL restart_registraR_count got=%0d exp=1", registra_pulsos); end
  endtask

  task automatic test_timeout();
    for (int k = 2; k <= 8; k++) begin
      tick();
      tests_run++;
      if (obs !== {F_NONE, 4'h2}) begin tests_failed++; $display("[TB] FAIL timeout_wait[%0d] got=%h exp=%h", k, obs, {F_NONE, 4'h2}); end
    end
    tick();
    tests_run++;
    if (obs !== {F_TO, 4'hD}) begin tests_failed++; $display("[TB] FAIL timeout_fim got=%h exp=%h", obs, {F_TO, 4'hD}); end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h2}) begin tests_failed++; $display("[TB] FAIL timeout_restart got=%h exp=%h", obs, {F_NONE, 4'h2}); end
    for (int k = 2; k <= 8; k++) tick();
    jogada_feita = 1'b1; igual = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_REG, 4'h4}) begin tests_failed++; $display("[TB] FAIL timeout_play_wins got=%h exp=%h", obs, {F_REG, 4'h4}); end
    jogada_feita = 1'b0;
    tick();
    tick();
    tests_run++;
    if (obs !== {F_ERR, 4'hE}) begin tests_failed++; $display("[TB] FAIL timeout_then_error got=%h exp=%h", obs, {F_ERR, 4'hE}); end
  endtask

  task automatic test_reset_mid();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    jogada_feita = 1'b1; igual = 1'b1; fimC = 1'b0;
    tick();
    jogada_feita = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h5}) begin tests_failed++; $display("[TB] FAIL midreset_comparacao got=%h exp=%h", obs, {F_NONE, 4'h5}); end
    reset = 1'b1;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h0}) begin tests_failed++; $display("[TB] FAIL midreset_inicial got=%h exp=%h", obs, {F_NONE, 4'h0}); end
    reset = 1'b0;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h0}) begin tests_failed++; $display("[TB] FAIL midreset_stay got=%h exp=%h", obs, {F_NONE, 4'h0}); end
  endtask

  task automatic test_illegal();
    iniciar = 1'b0;
    force dut.estado = estado_t'(4'h7);
    #1;
    release dut.estado;
    tick();
    tests_run++;
    if (obs !== {F_NONE, 4'h0}) begin tests_failed++; $display("[TB] FAIL illegal_code got=%h exp=%h", obs, {F_NONE, 4'h0}); end
  endtask

  initial begin
    test_reset();
    test_success();
    test_error();
    test_restart();
    test_timeout();
    test_reset_mid();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1, "[TB] watchdog");
  end

endmodule
